rv8_decode_issue: RTL and testbench

- Instruction decode/issue stage of the RISC-8 pipeline: the producer end of the ALU control interface.
- Accepts 16-bit instructions from fetch over a valid/ready handshake and decodes them into ALU select, register indices, immediate and operand-mux controls.
- Holds the result in a single ID/EX pipeline register with valid/ready toward EX.
- Tracks the destinations of the last two issued instructions to generate forwarding selects, and stops the pipe on HALT.

---
 rtl/rv8_decode_issue.sv | 182 ++++++++++++++++++
 tb/tb_rv8_decode_issue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rv8_decode_issue.sv
// RISC-8 decode/issue stage: decodes fetched instructions into a single ID/EX
// register and generates operand forwarding selects from a two-entry history.
module rv8_decode_issue #(
    parameter logic FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [15:0] if_instr,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_sel,
    output logic [1:0]  ex_rd,
    output logic [1:0]  ex_rs1,
    output logic [1:0]  ex_rs2,
    output logic [7:0]  ex_imm,
    output logic        ex_use_imm,
    output logic        ex_zero_a,
    output logic        ex_wr_en,
    output logic [1:0]  ex_fwd_a,
    output logic [1:0]  ex_fwd_b,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ALUR = 4'h1,
        OP_ADDI = 4'h2,
        OP_LDI  = 4'h3,
        OP_HALT = 4'hF
    } op_e;

    logic       accept;
    logic [3:0] d_sel;
    logic [1:0] d_rd, d_rs1, d_rs2;
    logic [7:0] d_imm;
    logic       d_use_imm, d_zero_a, d_wr_en;
    logic       d_halt, d_illegal;
    logic [1:0] d_fwd_a, d_fwd_b;

    logic [1:0] h1_rd, h2_rd;
    logic       h1_wr, h2_wr;
    logic [1:0] p1_rd, p2_rd;
    logic       p1_wr, p2_wr;

    assign if_ready = !halted && !flush && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;

    always_comb begin
        d_sel     = '0;
        d_rd      = '0;
        d_rs1     = '0;
        d_rs2     = '0;
        d_imm     = '0;
        d_use_imm = 1'b0;
        d_zero_a  = 1'b0;
        d_wr_en   = 1'b0;
        d_halt    = 1'b0;
        d_illegal = 1'b0;
        case (op_e'(if_instr[15:12]))
            OP_NOP: ;
            OP_ALUR: begin
                d_sel   = if_instr[11:8];
                d_rd    = if_instr[7:6];
                d_rs1   = if_instr[5:4];
                d_rs2   = if_instr[3:2];
                d_wr_en = 1'b1;
            end
            OP_ADDI: begin
                d_rd      = if_instr[11:10];
                d_rs1     = if_instr[9:8];
                d_imm     = if_instr[7:0];
                d_use_imm = 1'b1;
                d_wr_en   = 1'b1;
            end
            OP_LDI: begin
                d_rd      = if_instr[11:10];
                d_imm     = if_instr[7:0];
                d_use_imm = 1'b1;
                d_zero_a  = 1'b1;
                d_wr_en   = 1'b1;
            end
            OP_HALT: d_halt = 1'b1;
            default: d_illegal = 1'b1;
        endcase
    end

    // History as it will stand on the issue edge: shifted only when EX accepts.
    always_comb begin
        if (ex_ready) begin
            p1_rd = ex_rd;
            p1_wr = ex_valid && ex_wr_en;
            p2_rd = h2_rd;
            p2_wr = h2_wr;
            p2_rd = h1_rd;
            p2_wr = h1_wr;
        end else begin
            p1_rd = h1_rd;
            p1_wr = h1_wr;
            p2_rd = h2_rd;
            p2_wr = h2_wr;
        end
    end

    always_comb begin
        d_fwd_a = 2'b00;
        d_fwd_b = 2'b00;
        if (FWD_EN) begin
            if (!d_zero_a) begin
                if (p1_wr && p1_rd == d_rs1)      d_fwd_a = 2'b01;
                else if (p2_wr && p2_rd == d_rs1) d_fwd_a = 2'b10;
            end
            if (!d_use_imm) begin
                if (p1_wr && p1_rd == d_rs2)      d_fwd_b = 2'b01;
                else if (p2_wr && p2_rd == d_rs2) d_fwd_b = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_rd <= '0;
            h1_wr <= 1'b0;
            h2_rd <= '0;
            h2_wr <= 1'b0;
        end else if (flush) begin
            h1_rd <= '0;
            h1_wr <= 1'b0;
            h2_rd <= '0;
            h2_wr <= 1'b0;
        end else if (ex_ready) begin
            h2_rd <= h1_rd;
            h2_wr <= h1_wr;
            h1_rd <= ex_rd;
            h1_wr <= ex_valid && ex_wr_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_alu_sel <= '0;
            ex_rd      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_imm     <= '0;
            ex_use_imm <= 1'b0;
            ex_zero_a  <= 1'b0;
            ex_wr_en   <= 1'b0;
            ex_fwd_a   <= '0;
            ex_fwd_b   <= '0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            illegal <= accept && d_illegal;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (accept && d_halt) begin
                ex_valid <= 1'b0;
                halted   <= 1'b1;
            end else if (accept) begin
                ex_valid   <= 1'b1;
                ex_alu_sel <= d_sel;
                ex_rd      <= d_rd;
                ex_rs1     <= d_rs1;
                ex_rs2     <= d_rs2;
                ex_imm     <= d_imm;
                ex_use_imm <= d_use_imm;
                ex_zero_a  <= d_zero_a;
                ex_wr_en   <= d_wr_en;
                ex_fwd_a   <= d_fwd_a;
                ex_fwd_b   <= d_fwd_b;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv8_decode_issue.sv
// Directed bench for rv8_decode_issue: decode, handshake, forwarding, flush, HALT.
module tb_rv8_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_alu_sel;
    logic [1:0]  ex_rd, ex_rs1, ex_rs2;
    logic [7:0]  ex_imm;
    logic        ex_use_imm, ex_zero_a, ex_wr_en;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic        halted, illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv8_decode_issue #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_alu_sel(ex_alu_sel), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_imm(ex_imm), .ex_use_imm(ex_use_imm), .ex_zero_a(ex_zero_a),
        .ex_wr_en(ex_wr_en), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .halted(halted), .illegal(illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; flush = 1'b0; ex_ready = 1'b1;
        step(); step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", ex_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0h want=0", halted); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0h want=0", illegal); end
        total++; if ({ex_alu_sel, ex_rd, ex_imm, ex_fwd_a, ex_fwd_b, ex_wr_en} !== '0) begin
            bad++; $display("FAIL reset_fields got=%0h want=0", {ex_alu_sel, ex_rd, ex_imm, ex_fwd_a, ex_fwd_b, ex_wr_en});
        end
        rst_n = 1'b1;
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready got=%0h want=1", if_ready); end
    endtask

    task automatic test_alu_r();
        if_valid = 1'b1; if_instr = 16'h1236; ex_ready = 1'b1;
        step();
        if_valid = 1'b0;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL alur_valid got=%0h want=1", ex_valid); end
        total++; if (ex_alu_sel !== 4'd2) begin bad++; $display("FAIL alur_sel got=%0h want=2", ex_alu_sel); end
        total++; if ({ex_rd, ex_rs1, ex_rs2} !== {2'd0, 2'd3, 2'd1}) begin
            bad++; $display("FAIL alur_regs got=%0h/%0h/%0h want=0/3/1", ex_rd, ex_rs1, ex_rs2);
        end
        total++; if ({ex_wr_en, ex_use_imm, ex_zero_a, ex_imm} !== {3'b100, 8'h00}) begin
            bad++; $display("FAIL alur_ctl got wr=%0h ui=%0h za=%0h imm=%0h want 1/0/0/0", ex_wr_en, ex_use_imm, ex_zero_a, ex_imm);
        end
        total++; if ({ex_fwd_a, ex_fwd_b} !== 4'b0000) begin
            bad++; $display("FAIL alur_fwd got=%0h/%0h want=0/0", ex_fwd_a, ex_fwd_b);
        end
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL alur_drain got=%0h want=0", ex_valid); end
    endtask

    task automatic test_forwarding();
        if_valid = 1'b1; if_instr = 16'h3405;
        step();
        total++; if ({ex_valid, ex_rd, ex_imm, ex_use_imm, ex_zero_a, ex_wr_en, ex_alu_sel} !== {1'b1, 2'd1, 8'h05, 3'b111, 4'h0}) begin
            bad++; $display("FAIL ldi_fields got v=%0h rd=%0h imm=%0h ui=%0h za=%0h wr=%0h sel=%0h want 1/1/5/1/1/1/0",
                ex_valid, ex_rd, ex_imm, ex_use_imm, ex_zero_a, ex_wr_en, ex_alu_sel);
        end
        total++; if ({ex_rs1, ex_rs2, ex_fwd_a, ex_fwd_b} !== 8'h00) begin
            bad++; $display("FAIL ldi_unused got rs1=%0h rs2=%0h fa=%0h fb=%0h want 0", ex_rs1, ex_rs2, ex_fwd_a, ex_fwd_b);
        end
        if_instr = 16'h1054;
        step();
        total++; if ({ex_rd, ex_rs1, ex_rs2} !== {2'd1, 2'd1, 2'd1}) begin
            bad++; $display("FAIL add_regs got=%0h/%0h/%0h want=1/1/1", ex_rd, ex_rs1, ex_rs2);
        end
        total++; if ({ex_fwd_a, ex_fwd_b} !== 4'b0101) begin
            bad++; $display("FAIL fwd_ex got=%0h/%0h want=1/1", ex_fwd_a, ex_fwd_b);
        end
        if_instr = 16'h12A8;
        step();
        total++; if ({ex_rd, ex_fwd_a, ex_fwd_b} !== {2'd2, 4'b0000}) begin
            bad++; $display("FAIL unrelated got rd=%0h fa=%0h fb=%0h want 2/0/0", ex_rd, ex_fwd_a, ex_fwd_b);
        end
        if_instr = 16'h1254;
        step();
        total++; if ({ex_fwd_a, ex_fwd_b} !== 4'b1010) begin
            bad++; $display("FAIL fwd_wb got=%0h/%0h want=2/2", ex_fwd_a, ex_fwd_b);
        end
        if_instr = 16'h2E07;
        step();
        total++; if ({ex_rd, ex_rs1, ex_rs2, ex_imm, ex_use_imm, ex_zero_a, ex_alu_sel} !== {2'd3, 2'd2, 2'd0, 8'h07, 2'b10, 4'h0}) begin
            bad++; $display("FAIL addi_fields got rd=%0h rs1=%0h rs2=%0h imm=%0h ui=%0h za=%0h sel=%0h",
                ex_rd, ex_rs1, ex_rs2, ex_imm, ex_use_imm, ex_zero_a, ex_alu_sel);
        end
        total++; if ({ex_fwd_a, ex_fwd_b} !== 4'b1000) begin
            bad++; $display("FAIL addi_fwd got=%0h/%0h want=2/0", ex_fwd_a, ex_fwd_b);
        end
    endtask

    task automatic test_stall();
        if_valid = 1'b1; if_instr = 16'h105C; ex_ready = 1'b0;
        #1;
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL stall_if_ready got=%0h want=0", if_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({ex_valid, ex_rd, ex_rs1, ex_imm, ex_fwd_a} !== {1'b1, 2'd3, 2'd2, 8'h07, 2'b10}) begin
                bad++; $display("FAIL stall_hold cyc=%0d got v=%0h rd=%0h rs1=%0h imm=%0h fa=%0h", i, ex_valid, ex_rd, ex_rs1, ex_imm, ex_fwd_a);
            end
        end
        ex_ready = 1'b1;
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL unstall_if_ready got=%0h want=1", if_ready); end
        step();
        if_valid = 1'b0;
        total++; if ({ex_valid, ex_rs1, ex_rs2} !== {1'b1, 2'd1, 2'd3}) begin
            bad++; $display("FAIL unstall_issue got v=%0h rs1=%0h rs2=%0h want 1/1/3", ex_valid, ex_rs1, ex_rs2);
        end
        total++; if ({ex_fwd_a, ex_fwd_b} !== 4'b1001) begin
            bad++; $display("FAIL stall_history got=%0h/%0h want=2/1", ex_fwd_a, ex_fwd_b);
        end
        step();
    endtask

    task automatic test_illegal();
        if_valid = 1'b1; if_instr = 16'h7000;
        step();
        if_valid = 1'b0;
        total++; if ({ex_valid, ex_wr_en, ex_alu_sel} !== {2'b10, 4'h0}) begin
            bad++; $display("FAIL illegal_issue got v=%0h wr=%0h sel=%0h want 1/0/0", ex_valid, ex_wr_en, ex_alu_sel);
        end
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_pulse got=%0h want=1", illegal); end
        step();
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_width got=%0h want=0", illegal); end
    endtask

    task automatic test_flush();
        if_valid = 1'b1; if_instr = 16'h13C0;
        step();
        total++; if ({ex_valid, ex_rd} !== {1'b1, 2'd3}) begin
            bad++; $display("FAIL flush_pre got v=%0h rd=%0h want 1/3", ex_valid, ex_rd);
        end
        flush = 1'b1; if_instr = 16'h1000;
        #1;
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL flush_if_ready got=%0h want=0", if_ready); end
        step();
        flush = 1'b0;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h want=0", ex_valid); end
        if_instr = 16'h1030;
        step();
        if_valid = 1'b0;
        total++; if ({ex_valid, ex_rs1, ex_fwd_a} !== {1'b1, 2'd3, 2'b00}) begin
            bad++; $display("FAIL flush_history got v=%0h rs1=%0h fa=%0h want 1/3/0", ex_valid, ex_rs1, ex_fwd_a);
        end
        step();
    endtask

    task automatic test_halt();
        if_valid = 1'b1; if_instr = 16'hF000;
        step();
        total++; if ({halted, ex_valid, if_ready} !== 3'b100) begin
            bad++; $display("FAIL halt_set got h=%0h v=%0h rdy=%0h want 1/0/0", halted, ex_valid, if_ready);
        end
        if_instr = 16'h1236; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        total++; if ({halted, ex_valid, if_ready} !== 3'b100) begin
            bad++; $display("FAIL halt_sticky got h=%0h v=%0h rdy=%0h want 1/0/0", halted, ex_valid, if_ready);
        end
        if_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset got=%0h want=0", halted); end
        step();
        rst_n = 1'b1;
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL halt_resume got=%0h want=1", if_ready); end
    endtask

    task automatic test_reset_mid();
        if_valid = 1'b1; if_instr = 16'h7000;
        step();
        if_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if ({ex_valid, illegal} !== 2'b00) begin
            bad++; $display("FAIL midreset got v=%0h ill=%0h want 0/0", ex_valid, illegal);
        end
        step();
        rst_n = 1'b1;
        step();
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL midreset_pulse got=%0h want=0", illegal); end
    endtask

    initial begin
        test_reset();
        test_alu_r();
        test_forwarding();
        test_stall();
        test_illegal();
        test_flush();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
